alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_div.sv | 66 ++++++
 rtl/alu_seq_unit.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_XOR  = 4'h2,
    OP_NOT  = 4'h3,
    OP_NEG  = 4'h4,
    OP_ADD  = 4'h5,
    OP_SUB  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_SHRA = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB,
    OP_MUL  = 4'hC,
    OP_DIV  = 4'hD
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_div.sv
// Signed restoring divider: magnitude shift register plus sign fix-up.
// quo/rem present the fixed-up result of the step being taken this cycle.
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH:0]   rem_sh, trial;

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, dvs_q};
    if (load) begin
      // Magnitudes are unsigned, so the most-negative value needs no extra bit.
      quo_d     = a[WIDTH-1] ? -a : a;
      dvs_d     = b[WIDTH-1] ? -b : b;
      rem_d     = '0;
      neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem_d = a[WIDTH-1];
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
    quo = neg_quo_q ? -quo_d : quo_d;
    rem = neg_rem_q ? -rem_d : rem_d;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith/shift ops, Booth multiply, restoring divide.
// Handshake: start is taken only in IDLE; done pulses for one cycle as z_hi/z_lo update.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             div_zero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0] z_hi_q, z_hi_d, z_lo_q, z_lo_d;
  logic [WIDTH:0]   acc_q, acc_d, m_q, m_d, acc_sum;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             q1_q, q1_d;
  logic             last, div_load, div_step;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic [SW-1:0]      sh;
  logic [WIDTH:0]     sum_ext, dif_ext;
  logic [2*WIDTH-1:0] rol_ext, ror_ext;
  logic [WIDTH-1:0]   sc_hi, sc_lo;

  always_comb begin
    sh      = b[SW-1:0];
    sum_ext = {1'b0, a} + {1'b0, b};
    dif_ext = {1'b0, a} - {1'b0, b};
    rol_ext = {a, a} << sh;
    ror_ext = {a, a} >> sh;
    sc_hi   = '0;
    sc_lo   = '0;
    case (op)
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_XOR:  sc_lo = a ^ b;
      OP_NOT:  sc_lo = ~a;
      OP_NEG:  sc_lo = -a;
      OP_ADD: begin
        sc_lo = sum_ext[WIDTH-1:0];
        sc_hi = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
      end
      OP_SUB: begin
        sc_lo = dif_ext[WIDTH-1:0];
        sc_hi = {{(WIDTH-1){1'b0}}, dif_ext[WIDTH]};
      end
      OP_SHL:  sc_lo = a << sh;
      OP_SHR:  sc_lo = a >> sh;
      OP_SHRA: sc_lo = $signed(a) >>> sh;
      OP_ROL:  sc_lo = rol_ext[2*WIDTH-1:WIDTH];
      OP_ROR:  sc_lo = ror_ext[WIDTH-1:0];
      default: ;
    endcase
  end

  // Accumulator carries one guard bit so subtracting a most-negative multiplicand cannot overflow.
  always_comb begin
    case ({mq_q[0], q1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    z_hi_d   = z_hi_q;
    z_lo_d   = z_lo_q;
    acc_d    = acc_q;
    m_d      = m_q;
    mq_d     = mq_q;
    q1_d     = q1_q;
    div_load = 1'b0;
    div_step = 1'b0;
    last     = (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d = ST_MUL;
            busy_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            m_d     = {a[WIDTH-1], a};
            mq_d    = b;
            q1_d    = 1'b0;
          end else if (op == OP_DIV && b != '0) begin
            state_d  = ST_DIV;
            busy_d   = 1'b1;
            cnt_d    = '0;
            div_load = 1'b1;
          end else if (op == OP_DIV) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
            z_hi_d = a;
            z_lo_d = '1;
          end else begin
            done_d = 1'b1;
            dz_d   = 1'b0;
            z_hi_d = sc_hi;
            z_lo_d = sc_lo;
          end
        end
      end
      ST_MUL: begin
        acc_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        mq_d  = {acc_sum[0], mq_q[WIDTH-1:1]};
        q1_d  = mq_q[0];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          z_hi_d  = acc_sum[WIDTH:1];
          z_lo_d  = {acc_sum[0], mq_q[WIDTH-1:1]};
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          z_hi_d  = div_rem;
          z_lo_d  = div_quo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      mq_q    <= mq_d;
      q1_q    <= q1_d;
    end
  end

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .Clock (Clock),
    .Clear (Clear),
    .load  (div_load),
    .step  (div_step),
    .a     (a),
    .b     (b),
    .quo   (div_quo),
    .rem   (div_rem)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign z_hi     = z_hi_q;
  assign z_lo     = z_lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit (WIDTH=32): directed corner cases plus random ops against a reference model.
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  logic        Clock, Clear, start;
  logic [3:0]  op;
  logic [31:0] a, b, z_hi, z_lo;
  logic        busy, done, div_zero;
  int          checks = 0;
  int          failures = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .z_hi     (z_hi),
    .z_lo     (z_lo),
    .div_zero (div_zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: results from plain signed/unsigned arithmetic; latency in cycles after start.
  function automatic void model(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int lat);
    longint      sa, sb;
    logic [63:0] wide;
    int          sh;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    sh  = int'(mb % 32);
    hi  = '0;
    lo  = '0;
    dz  = 1'b0;
    lat = 1;
    case (mop)
      OP_AND: lo = ma & mb;
      OP_OR:  lo = ma | mb;
      OP_XOR: lo = ma ^ mb;
      OP_NOT: lo = ~ma;
      OP_NEG: lo = 32'd0 - ma;
      OP_ADD: begin
        wide = {32'd0, ma} + {32'd0, mb};
        lo = wide[31:0];
        hi = {31'd0, wide[32]};
      end
      OP_SUB: begin
        lo = ma - mb;
        hi = (ma < mb) ? 32'd1 : 32'd0;
      end
      OP_SHL: lo = ma << sh;
      OP_SHR: lo = ma >> sh;
      OP_SHRA: begin
        lo = ma;
        repeat (sh) lo = {lo[31], lo[31:1]};
      end
      OP_ROL: begin
        lo = ma;
        repeat (sh) lo = {lo[30:0], lo[31]};
      end
      OP_ROR: begin
        lo = ma;
        repeat (sh) lo = {lo[0], lo[31:1]};
      end
      OP_MUL: begin
        wide = 64'(sa * sb);
        hi = wide[63:32];
        lo = wide[31:0];
        lat = 33;
      end
      OP_DIV: begin
        if (mb == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = ma;
          dz = 1'b1;
        end else begin
          wide = 64'(sa / sb);
          lo = wide[31:0];
          wide = 64'(sa % sb);
          hi = wide[31:0];
          lat = 33;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one op, optionally pulsing start again at cycle 'inject', and score the completion.
  task automatic run_op(input string tag, input logic [3:0] rop, input logic [31:0] ra,
                        input logic [31:0] rb, input int inject);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          e_lat, n, bcnt;
    model(rop, ra, rb, e_hi, e_lo, e_dz, e_lat);
    start = 1'b1;
    op = rop;
    a = ra;
    b = rb;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 1;
    bcnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bcnt++;
      if (inject > 0 && n == inject) begin
        start = 1'b1;
        op = OP_ADD;
      end
      tick();
      start = 1'b0;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(e_lat));
    check({tag, ".busy_cycles"}, 64'(bcnt), (e_lat == 33) ? 64'd32 : 64'd0);
    check({tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, ".z_hi"}, {32'd0, z_hi}, {32'd0, e_hi});
    check({tag, ".z_lo"}, {32'd0, z_lo}, {32'd0, e_lo});
    check({tag, ".div_zero"}, {63'd0, div_zero}, {63'd0, e_dz});
    tick();
    check({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, ".hold"}, {z_hi, z_lo}, {e_hi, e_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          n;
    Clear = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #1;
    check("reset.busy", {63'd0, busy}, 64'd0);
    check("reset.done", {63'd0, done}, 64'd0);
    check("reset.z", {z_hi, z_lo}, 64'd0);
    check("reset.div_zero", {63'd0, div_zero}, 64'd0);
    tick();
    tick();
    Clear = 1'b1;
    tick();

    run_op("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd7, 10);
    check("mul_neg.const", {z_hi, z_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg.const", {z_hi, z_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_zero", OP_DIV, 32'd5, 32'd0, 0);
    run_op("add_after_dz", OP_ADD, 32'd3, 32'd4, 0);
    run_op("shra", OP_SHRA, 32'h8000_0000, 32'd31, 0);
    run_op("ror", OP_ROR, 32'd1, 32'd33, 0);
    check("ror.const", {32'd0, z_lo}, 64'h8000_0000);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mul_minmin", OP_MUL, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("sub_borrow", OP_SUB, 32'd1, 32'd2, 0);
    run_op("undef_e", 4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("undef_f", 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 36; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      run_op("rand", rop, ra, rb, 0);
    end

    // Abort a divide mid-flight; leave nonzero state beforehand so the clear is visible.
    run_op("pre_clear", OP_DIV, 32'd9, 32'd0, 0);
    start = 1'b1;
    op = OP_DIV;
    a = 32'd1000;
    b = 32'd3;
    tick();
    start = 1'b0;
    n = 1;
    while (n < 12) begin
      tick();
      n++;
    end
    Clear = 1'b0;
    #1;
    check("clr.busy", {63'd0, busy}, 64'd0);
    check("clr.done", {63'd0, done}, 64'd0);
    check("clr.z", {z_hi, z_lo}, 64'd0);
    check("clr.div_zero", {63'd0, div_zero}, 64'd0);
    tick();
    tick();
    Clear = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    check("clr.no_done", 64'(n), 64'd0);
    run_op("mul_after_clr", OP_MUL, 32'd6, 32'd7, 0);
    check("mul_after_clr.const", {32'd0, z_lo}, 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
